// File: rtl/serial_mac_accum.sv
// Bit-serial keyed CRC-16 tag accumulator: frames MSB-first bits between sof/eof
// and emits one registered tag per completed frame; overlong frames raise err_len.
module serial_mac_accum #(
  parameter logic [15:0] POLY     = 16'h1021,
  parameter logic [15:0] KEY      = 16'hFFFF,
  parameter int unsigned MAX_BITS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        sof,
  input  logic        eof,
  output logic [15:0] mac,
  output logic        mac_valid,
  output logic        busy,
  output logic        err_len,
  output logic [8:0]  bit_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  localparam logic [8:0] MAX_CNT = 9'(MAX_BITS);

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb       = crc[15] ^ b;
    crc_step = {crc[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
  endfunction

  state_t      state_q,     state_d;
  logic [15:0] crc_q,       crc_d;
  logic [15:0] mac_q,       mac_d;
  logic        mac_valid_q, mac_valid_d;
  logic        busy_q,      busy_d;
  logic        err_len_q,   err_len_d;
  logic [8:0]  bit_count_q, bit_count_d;
  logic [15:0] stepped_s;
  logic        start_s;

  // Next-state and next-output computation for the framing FSM.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    mac_d       = mac_q;
    mac_valid_d = 1'b0;
    err_len_d   = err_len_q;
    bit_count_d = bit_count_q;
    start_s     = bit_valid & sof;
    // A start always reseeds from KEY, regardless of the running value.
    stepped_s   = crc_step(start_s ? KEY : crc_q, bit_in);

    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start_s) begin
          crc_d       = stepped_s;
          bit_count_d = 9'd1;
          err_len_d   = 1'b0;
          state_d     = ST_ACCUM;
        end else begin
          state_d = state_q;
        end
      end
      ST_ACCUM: begin
        if (start_s) begin
          crc_d       = stepped_s;
          bit_count_d = 9'd1;
          err_len_d   = 1'b0;
          state_d     = ST_ACCUM;
        end else if (bit_valid) begin
          if (bit_count_q == MAX_CNT) begin
            err_len_d = 1'b1;
            state_d   = ST_ERROR;
          end else begin
            crc_d       = stepped_s;
            bit_count_d = bit_count_q + 9'd1;
            state_d     = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // An accepted eof bit closes the frame unless it just tripped the length limit.
    if (bit_valid && eof && (state_d == ST_ACCUM) && (start_s || state_q == ST_ACCUM)) begin
      mac_d       = crc_d;
      mac_valid_d = 1'b1;
      state_d     = ST_IDLE;
    end else begin
      mac_valid_d = 1'b0;
    end

    busy_d = (state_d == ST_ACCUM);
  end

  // State and output registers with synchronous reset overriding all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      crc_q       <= KEY;
      mac_q       <= 16'h0000;
      mac_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_len_q   <= 1'b0;
      bit_count_q <= 9'd0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      mac_q       <= mac_d;
      mac_valid_q <= mac_valid_d;
      busy_q      <= busy_d;
      err_len_q   <= err_len_d;
      bit_count_q <= bit_count_d;
    end
  end

  assign mac       = mac_q;
  assign mac_valid = mac_valid_q;
  assign busy      = busy_q;
  assign err_len   = err_len_q;
  assign bit_count = bit_count_q;

endmodule

// File: doc/serial_mac_accum.md
# serial_mac_accum

Bit-serial keyed CRC-16 message-authentication accumulator. Sits directly downstream of the registered data flop (`dff`) in the integrated ECC/MAC datapath. It consumes one bit per clock from that flop's `q` output. It frames the bits with start/end markers and emits a 16-bit tag per frame for comparison against the received MAC. Overlong frames are flagged and no tag is produced for them.

## Interface
- `POLY`, 16'h1021, CRC generator polynomial (implicit x^16 term)
- `KEY`, 16'hFFFF, keyed initial register value loaded at frame start
- `MAX_BITS`, 256, maximum legal frame length in bits (≤ 511)
- `clk`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `bit_in`  in  1  serial data bit (driven from upstream flop `q`)
- `bit_valid`  in  1  `bit_in` is valid this cycle
- `sof`  in  1  qualified by `bit_valid`: this bit is the first of a frame
- `eof`  in  1  qualified by `bit_valid`: this bit is the last of a frame
- `mac`  out  16  tag of last completed frame
- `mac_valid`  out  1  one-cycle pulse: `mac` updated this cycle
- `busy`  out  1  frame in progress (state ACCUM)
- `err_len`  out  1  sticky: current frame exceeded `MAX_BITS`
- `bit_count`  out  9  bits accepted in current/last frame

## Operation
- **Reset values:** state IDLE, `crc`=`KEY`, `mac`=0, `mac_valid`=0, `busy`=0, `err_len`=0, `bit_count`=0.
- **Step function** (MSB-first):
  - fb = crc[15] ^ bit
  - crc' = {crc[14:0],0} ^ (fb ? `POLY` : 0)
- **States:**
  - **IDLE:**
    - `bit_valid` & `sof`: crc ← step(`KEY`, bit), `bit_count` ← 1, `err_len` ← 0.
    - If `eof` is also set, the frame completes in the same cycle (see eof rule). Otherwise go to ACCUM.
    - `bit_valid` without `sof` is ignored.
  - **ACCUM:**
    - `bit_valid` & `sof`: restart. crc ← step(`KEY`, bit), `bit_count` ← 1, the partial frame is discarded, and no `mac_valid` is issued.
    - `bit_valid` & !`sof`: if `bit_count` == `MAX_BITS`, go to ERROR with `err_len` ← 1. Otherwise crc ← step(crc, bit) and `bit_count`++.
    - `bit_valid` low: hold all state.
  - **ERROR:**
    - All bits are ignored except `bit_valid` & `sof`, which behaves as in IDLE. That start clears `err_len`.
    - No `mac_valid` is issued for the errored frame.
- **eof rule:** when the accepted bit carries `eof` and no length error occurs:
  - `mac` ← stepped crc value.
  - `mac_valid` ← 1 for exactly one cycle.
  - Next state IDLE.
  - `bit_count` keeps the final count.
- **Ignored inputs:** `sof` and `eof` are ignored when `bit_valid` = 0.
- **Hold behaviour:** `mac` holds until the next completed frame. `busy` = (state == ACCUM).

## Timing
- All outputs are registered.
- **Tag latency:** `mac` and `mac_valid` appear in the cycle after the edge that samples the `eof` bit, i.e. 1 clock after the last bit.
- **Throughput:** one bit per clock. Back-to-back frames are legal: a `sof` on the cycle immediately after an `eof` starts a new frame while `mac_valid` from the previous frame is high.
- **Single-bit frame** (`sof`&`eof` together): the tag is available 1 cycle later.
- **`err_len`** asserts the cycle after the (`MAX_BITS`+1)th bit is sampled.
- **Reset mid-frame:** reset asserted on any edge returns all reset values at that edge, overriding every input including a simultaneous `eof`. No `mac_valid` is issued.

## Test plan
- **Single-bit frames** (defaults): `sof`=`eof`=1, `bit_in`=0 → `mac`=16'hEFDF with a 1-cycle `mac_valid`, `bit_count`=1. Repeat with `bit_in`=1 → `mac`=16'hFFFE.
- **ASCII "123456789"**: 72 bits MSB-first, `bit_valid` continuous → `mac`=16'h29B1 one cycle after the last bit, `bit_count`=72, `busy` high for 71 cycles. Byte 0x41 alone → 16'hB915.
- **Gapped input:** same "123456789" stream with `bit_valid` deasserted every other cycle → identical `mac`=16'h29B1; `busy` stays high through the gaps.
- **Overlong frame:** 257 bits with no `eof` → `err_len`=1 after bit 257 and no `mac_valid`. A following `sof` frame of 0x41 → `err_len` cleared, `mac`=16'hB915.
- **Restart:** `sof` mid-frame after 20 bits, then "123456789" → a single `mac_valid` with 16'h29B1. Back-to-back frames 0x41, 0x41 with no gap → two `mac_valid` pulses 8 cycles apart, both 16'hB915.
- **Reset:** assert `reset` on the cycle carrying `eof` → no `mac_valid`, `mac`=0, `bit_count`=0, state IDLE.
